ks4_serial_adder: RTL and testbench

//  Digit-serial WIDTH-bit adder. Accepts one operand pair plus carry-in through a

---
 rtl/ks4_serial_adder.sv | 80 ++++++++
 tb/tb_ks4_serial_adder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ks4_serial_adder.sv
// ks4_serial_adder: digit-serial adder that feeds one nibble per cycle into a 4-bit Kogge-Stone core
module ks4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] p, g, g1, g2;
    logic [1:0] p1;
    always_comb begin
        p = a ^ b;
        g = a & b;
        g[0] = g[0] | (p[0] & cin);
        g1 = {g[3:1] | (p[3:1] & g[2:0]), g[0]};
        p1 = p[3:2] & p[2:1];
        g2 = {g1[3:2] | (p1 & g1[1:0]), g1[1:0]};
        s = p ^ {g2[2:0], cin};
        cout = g2[3];
    end
endmodule

module ks4_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NIB = WIDTH / 4;
    localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0] state;
    logic [IW-1:0] idx;
    logic [WIDTH-1:0] op_a, op_b;
    logic carry, c, last;
    logic [3:0] s;
    ks4 u_ks4 (.a(op_a[4*idx+:4]), .b(op_b[4*idx+:4]), .cin(carry), .s(s), .cout(c));
    assign last = idx == IW'(NIB - 1);
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    // the carry register after the final step is the architectural carry-out
    assign cout = carry;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            carry <= 1'b0;
            sum <= '0;
            overflow <= 1'b0;
            op_a <= '0;
            op_b <= '0;
        end else if (state == IDLE && in_valid) begin
            op_a <= a;
            op_b <= b;
            carry <= cin;
            idx <= '0;
            state <= RUN;
        end else if (state == RUN) begin
            sum[4*idx+:4] <= s;
            carry <= c;
            idx <= last ? idx : idx + 1'b1;
            if (last) begin
                overflow <= c ^ op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ s[3];
                state <= DONE;
            end
        end else if (state == DONE && out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_ks4_serial_adder.sv
// tb_ks4_serial_adder: table vectors, handshake corner cases and randomized ops on WIDTH=16 and WIDTH=4 instances
module tb_ks4_serial_adder;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic iv[2], ir[2], ov[2], ordy[2], ic[2], co[2], of[2];
    logic [15:0] ia[2], ib[2], s16;
    logic [3:0] s4;
    int vectors = 0, errs = 0;

    ks4_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(ia[0]), .b(ib[0]), .cin(ic[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum(s16), .cout(co[0]), .overflow(of[0]));
    ks4_serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(ia[1][3:0]), .b(ib[1][3:0]), .cin(ic[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(s4), .cout(co[1]), .overflow(of[1]));

    typedef struct {
        logic [15:0] a, b;
        logic        c;
        logic [15:0] s;
        logic        co, ov;
    } vec_t;
    vec_t tv[7];

    localparam int N = 500;
    logic [17:0] em[2][512];
    int wr[2], rd[2], sent[2];
    bit lf[2];

    function automatic logic [15:0] gs(input int d);
        return d != 0 ? {12'b0, s4} : s16;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // {overflow, cout, sum} from plain integer arithmetic on unsigned and signed views
    function automatic logic [17:0] ref_add(input int w, input logic [15:0] a, input logic [15:0] b, input logic c);
        longint m, full, sa, sb, r;
        m = longint'(1) << w;
        full = longint'(a) + longint'(b) + longint'(c);
        sa = a[w-1] ? longint'(a) - m : longint'(a);
        sb = b[w-1] ? longint'(b) - m : longint'(b);
        r = sa + sb + longint'(c);
        return {(r >= m / 2) || (r < -(m / 2)), full >= m, 16'(full % m)};
    endfunction

    task automatic op(input int d, input logic [15:0] a, input logic [15:0] b, input logic c,
                      output logic [15:0] s, output logic co_o, output logic ov_o, output int lat);
        int g = 0;
        @(negedge clk);
        while (!ir[d] && g < 50) begin
            @(negedge clk);
            g++;
        end
        ia[d] = a;
        ib[d] = b;
        ic[d] = c;
        iv[d] = 1'b1;
        @(negedge clk);
        iv[d] = 1'b0;
        lat = 0;
        while (!ov[d] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        s = gs(d);
        co_o = co[d];
        ov_o = of[d];
    endtask

    initial begin
        logic [15:0] s, held;
        logic c, v;
        int lat, w;
        logic [15:0] mask;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0;
            ordy[d] = 1'b1;
            ia[d] = '0;
            ib[d] = '0;
            ic[d] = 1'b0;
            wr[d] = 0;
            rd[d] = 0;
            sent[d] = 0;
            lf[d] = 1'b0;
        end
        tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tv[2] = '{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0};
        tv[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tv[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tv[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tv[6] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset in_ready", 32'(ir[d]), 1);
            chk("reset out_valid", 32'(ov[d]), 0);
            chk("reset sum", 32'(gs(d)), 0);
            chk("reset cout", 32'(co[d]), 0);
            chk("reset overflow", 32'(of[d]), 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            op(0, tv[i].a, tv[i].b, tv[i].c, s, c, v, lat);
            chk($sformatf("vec%0d sum", i), 32'(s), 32'(tv[i].s));
            chk($sformatf("vec%0d cout", i), 32'(c), 32'(tv[i].co));
            chk($sformatf("vec%0d overflow", i), 32'(v), 32'(tv[i].ov));
            chk($sformatf("vec%0d latency", i), 32'(lat), 4);
        end

        op(1, 16'hF, 16'h1, 1'b0, s, c, v, lat);
        chk("w4 wrap sum", 32'(s), 0);
        chk("w4 wrap cout", 32'(c), 1);
        chk("w4 wrap overflow", 32'(v), 0);
        chk("w4 latency", 32'(lat), 1);
        op(1, 16'h7, 16'h1, 1'b0, s, c, v, lat);
        chk("w4 ovf sum", 32'(s), 8);
        chk("w4 ovf overflow", 32'(v), 1);

        ordy[0] = 1'b0;
        op(0, 16'h1111, 16'h2222, 1'b0, s, c, v, lat);
        chk("bp sum", 32'(s), 32'h3333);
        held = s;
        repeat (5) begin
            @(negedge clk);
            chk("bp sum stable", 32'(s16), 32'(held));
            chk("bp in_ready low", 32'(ir[0]), 0);
            chk("bp out_valid high", 32'(ov[0]), 1);
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("bp release in_ready", 32'(ir[0]), 1);
        chk("bp release out_valid", 32'(ov[0]), 0);

        ia[0] = 16'h1234;
        ib[0] = 16'h4321;
        ic[0] = 1'b0;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun rst out_valid", 32'(ov[0]), 0);
        chk("midrun rst in_ready", 32'(ir[0]), 1);
        chk("midrun rst sum", 32'(s16), 0);
        rst = 1'b0;
        op(0, 16'h0003, 16'h0004, 1'b0, s, c, v, lat);
        chk("post rst sum", 32'(s), 7);

        for (int cyc = 0; cyc < 40000 && (rd[0] < N || rd[1] < N); cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                w = d != 0 ? 4 : 16;
                mask = d != 0 ? 16'h000F : 16'hFFFF;
                if (lf[d]) iv[d] = 1'b0;
                if (!iv[d] && sent[d] < N && $urandom_range(2) == 0) begin
                    ia[d] = 16'($urandom) & mask;
                    ib[d] = 16'($urandom) & mask;
                    ic[d] = 1'($urandom);
                    iv[d] = 1'b1;
                end
                ordy[d] = $urandom_range(3) != 0;
                lf[d] = iv[d] && ir[d];
                if (lf[d]) begin
                    em[d][wr[d]] = ref_add(w, ia[d], ib[d], ic[d]);
                    wr[d]++;
                    sent[d]++;
                end
                if (ov[d] && ordy[d]) begin
                    if (rd[d] < wr[d]) begin
                        chk($sformatf("rand w%0d op%0d {ovf,cout,sum}", w, rd[d]),
                            32'({of[d], co[d], gs(d)}), 32'(em[d][rd[d]]));
                        rd[d]++;
                    end else begin
                        vectors++;
                        errs++;
                        $display("FAIL rand w%0d extra result: got %h with none outstanding", w, gs(d));
                    end
                end
            end
        end
        chk("w16 results received", 32'(rd[0]), N);
        chk("w4 results received", 32'(rd[1]), N);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
